// File: rtl/bitstream_decoder.sv
// Decodes parallel unipolar stochastic bitstreams back to binary by counting ones per channel
// over a compute window, latching the counts and window length when the window closes.
module bitstream_decoder #(
   parameter int CHANNELS = 3,
   parameter int LENGTH   = 256,
   parameter int WIDTH    = $clog2(LENGTH + 1)
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      compute,
   input  logic [CHANNELS-1:0]       bitstream_in,
   output logic [CHANNELS*WIDTH-1:0] count_out,
   output logic [WIDTH-1:0]          window_len,
   output logic                      valid_out,
   output logic                      done,
   output logic                      overflow
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   localparam logic [WIDTH-1:0] LEN_MAX = WIDTH'(LENGTH);

   logic [1:0]                     state_q,    state_d;
   logic [CHANNELS-1:0][WIDTH-1:0] acc_q,      acc_d;
   logic [WIDTH-1:0]               len_q,      len_d;
   logic                           ovfAcc_q,   ovfAcc_d;
   logic [CHANNELS-1:0][WIDTH-1:0] countOut_q, countOut_d;
   logic [WIDTH-1:0]               winLen_q,   winLen_d;
   logic                           valid_q,    valid_d;
   logic                           done_q,     done_d;
   logic                           ovf_q,      ovf_d;

   // The window-opening edge already counts its bits; the latched result stays visible
   // until a later window closes, and len saturates at LENGTH rather than wrapping.
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      len_d      = len_q;
      ovfAcc_d   = ovfAcc_q;
      countOut_d = countOut_q;
      winLen_d   = winLen_q;
      valid_d    = valid_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;

      case (state_q)
         IDLE, HOLD: begin
            if (compute) begin
               state_d = COUNT;
               for (int c = 0; c < CHANNELS; c++) begin
                  acc_d[c] = WIDTH'(bitstream_in[c]);
               end
               len_d    = WIDTH'(1);
               ovfAcc_d = 1'b0;
               valid_d  = 1'b0;
            end
         end
         COUNT: begin
            if (compute) begin
               if (len_q < LEN_MAX) begin
                  for (int c = 0; c < CHANNELS; c++) begin
                     acc_d[c] = acc_q[c] + WIDTH'(bitstream_in[c]);
                  end
                  len_d = len_q + WIDTH'(1);
               end else begin
                  ovfAcc_d = 1'b1;
               end
            end else begin
               countOut_d = acc_q;
               winLen_d   = len_q;
               ovf_d      = ovfAcc_q;
               valid_d    = 1'b1;
               done_d     = 1'b1;
               acc_d      = '0;
               len_d      = '0;
               state_d    = HOLD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         acc_q      <= '0;
         len_q      <= '0;
         ovfAcc_q   <= 1'b0;
         countOut_q <= '0;
         winLen_q   <= '0;
         valid_q    <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         len_q      <= len_d;
         ovfAcc_q   <= ovfAcc_d;
         countOut_q <= countOut_d;
         winLen_q   <= winLen_d;
         valid_q    <= valid_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
      end
   end

   assign count_out  = countOut_q;
   assign window_len = winLen_q;
   assign valid_out  = valid_q;
   assign done       = done_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Scoreboard bench for bitstream_decoder: directed windows push hand-computed results,
// and a monitor compares them whenever the decoder pulses done.
module tb_bitstream_decoder;

   localparam int CHANNELS = 3;
   localparam int LENGTH   = 256;
   localparam int WIDTH    = 9;

   logic                      clk;
   logic                      n_rst;
   logic                      compute;
   logic [CHANNELS-1:0]       bitstream_in;
   logic [CHANNELS*WIDTH-1:0] count_out;
   logic [WIDTH-1:0]          window_len;
   logic                      valid_out;
   logic                      done;
   logic                      overflow;

   typedef struct {
      int c0;
      int c1;
      int c2;
      int len;
      int ovf;
   } expT;

   expT sbQ[$];
   int  checkCount = 0;
   int  passCount  = 0;
   int  doneSeen   = 0;
   int  windowsPushed = 0;

   bitstream_decoder #(
      .CHANNELS(CHANNELS),
      .LENGTH  (LENGTH)
   ) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .compute     (compute),
      .bitstream_in(bitstream_in),
      .count_out   (count_out),
      .window_len  (window_len),
      .valid_out   (valid_out),
      .done        (done),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      checkCount++;
      if (act == exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [CHANNELS-1:0] patternBits(input int mode, input int i);
      logic [CHANNELS-1:0] b;
      case (mode)
         0:       b = 3'b000;
         1:       b = 3'b111;
         2:       b = {(i % 4 == 0), 1'b1, (i % 2 == 0)};
         3:       b = 3'b011;
         4:       b = 3'b100;
         default: b = 3'b000;
      endcase
      return b;
   endfunction

   task automatic pushExp(input int c0, input int c1, input int c2, input int len, input int ovf);
      expT e;
      e.c0 = c0; e.c1 = c1; e.c2 = c2; e.len = len; e.ovf = ovf;
      sbQ.push_back(e);
      windowsPushed++;
   endtask

   // Drives nHigh open-window edges, then optionally the single low edge that closes the window.
   task automatic applyStimulus(input int nHigh, input int mode, input bit doClose);
      for (int i = 0; i < nHigh; i++) begin
         compute      = 1'b1;
         bitstream_in = patternBits(mode, i);
         @(posedge clk); #1;
      end
      if (doClose) begin
         compute      = 1'b0;
         bitstream_in = 3'b000;
         @(posedge clk); #1;
      end
   endtask

   task automatic idleCycles(input int n);
      compute      = 1'b0;
      bitstream_in = 3'b000;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expected window.
   initial begin
      expT e;
      forever begin
         @(negedge clk);
         if (n_rst && done) begin
            doneSeen++;
            if (sbQ.size() == 0) begin
               checkCount++;
               $display("[TB] FAIL unexpected_done: got done=1 with empty scoreboard, expected no pulse");
            end else begin
               e = sbQ.pop_front();
               checkOutput("count_ch0", int'(count_out[WIDTH-1:0]), e.c0);
               checkOutput("count_ch1", int'(count_out[2*WIDTH-1:WIDTH]), e.c1);
               checkOutput("count_ch2", int'(count_out[3*WIDTH-1:2*WIDTH]), e.c2);
               checkOutput("window_len", int'(window_len), e.len);
               checkOutput("overflow", int'(overflow), e.ovf);
               checkOutput("valid_out", int'(valid_out), 1);
            end
         end
      end
   end

   initial begin
      n_rst        = 1'b0;
      compute      = 1'b0;
      bitstream_in = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_count_out", int'(count_out), 0);
      checkOutput("reset_window_len", int'(window_len), 0);
      checkOutput("reset_valid", int'(valid_out), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_overflow", int'(overflow), 0);
      n_rst = 1'b1;
      idleCycles(2);
      checkOutput("idle_no_done", int'(done), 0);

      pushExp(256, 256, 256, 256, 0);
      applyStimulus(256, 1, 1'b1);
      idleCycles(2);

      pushExp(0, 0, 0, 256, 0);
      applyStimulus(256, 0, 1'b1);
      idleCycles(2);

      pushExp(128, 256, 64, 256, 0);
      applyStimulus(256, 2, 1'b1);
      idleCycles(2);

      pushExp(256, 256, 256, 256, 1);
      applyStimulus(300, 1, 1'b1);
      idleCycles(1);
      pushExp(0, 0, 0, 10, 0);
      applyStimulus(10, 0, 1'b1);
      idleCycles(2);

      // Back-to-back: window B opens on the edge right after A's closing edge.
      pushExp(5, 5, 0, 5, 0);
      applyStimulus(5, 3, 1'b1);
      applyStimulus(1, 4, 1'b0);
      checkOutput("b2b_valid_drop", int'(valid_out), 0);
      checkOutput("b2b_hold_count", int'(count_out), (5 << WIDTH) | 5);
      checkOutput("b2b_hold_len", int'(window_len), 5);
      pushExp(0, 0, 7, 7, 0);
      applyStimulus(6, 4, 1'b1);
      idleCycles(2);
      checkOutput("hold_valid", int'(valid_out), 1);

      applyStimulus(100, 1, 1'b0);
      n_rst = 1'b0;
      #1;
      checkOutput("async_rst_count", int'(count_out), 0);
      checkOutput("async_rst_len", int'(window_len), 0);
      checkOutput("async_rst_valid", int'(valid_out), 0);
      checkOutput("async_rst_done", int'(done), 0);
      checkOutput("async_rst_ovf", int'(overflow), 0);
      compute = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
      idleCycles(2);

      pushExp(256, 256, 256, 256, 0);
      applyStimulus(256, 1, 1'b1);
      idleCycles(3);

      checkOutput("scoreboard_empty", sbQ.size(), 0);
      checkOutput("done_pulse_count", doneSeen, windowsPushed);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
